fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage, directly upstream of the FEC->DEC pipeline register.
//  - Owns the PC and drives a synchronous-read instruction memory with a fixed 1-cycle read latency.
//  - Presents PCF/instrF/PCPlus4F/validF for the FEC->DEC register to latch.
//  - Supports hazard-unit stalls (one-entry hold buffer) and branch/jump redirect from EXE.
// PARAMETERS
//  WIDTH      32            address/data width
//  RESET_PC   32'h00000000  first fetch address after reset
//  NOP_INSTR  32'h00000013  instrF value while validF=0 (addi x0,x0,0)
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      asynchronous, active-high reset
//  StallF     in   1      hold current output, issue no new request
//  PCSrcE     in   1      redirect request from EXE
//  PCTargetE  in   WIDTH  redirect target; bits[1:0] ignored, forced to 0
//  imem_req   out  1      read request this cycle
//  imem_addr  out  WIDTH  read address (= faddr)
//  imem_rdata in   WIDTH  data for the address requested in the previous cycle
//  PCF        out  WIDTH  PC of presented instruction
//  instrF     out  WIDTH  presented instruction
//  PCPlus4F   out  WIDTH  PCF+4, modulo 2^WIDTH
//  validF     out  1      presented instruction is real and on the correct path
// BEHAVIOUR
//  State
//  - faddr: next fetch address.
//  - rsp_valid/rsp_pc: a response is due on imem_rdata this cycle.
//  - hold_valid/hold_instr/hold_pc: one-entry hold buffer.
//  Reset (async, immediate)
//  - faddr=RESET_PC; rsp_valid=0; hold_valid=0; rsp_pc=hold_pc=0.
//  - Outputs during reset: validF=0, instrF=NOP_INSTR, PCF=0, PCPlus4F=4, imem_req=0.
//  Request
//  - imem_req = ~rst & ~StallF & ~PCSrcE.
//  - On issue: faddr<=faddr+4 (wraps modulo 2^WIDTH); rsp_valid<=1; rsp_pc<=faddr.
//  - No issue: rsp_valid<=0, except while stalled (see Stall).
//  Output select
//  - If hold_valid: output the hold buffer.
//  - Else if rsp_valid: output imem_rdata with PCF=rsp_pc.
//  - Else: instrF=NOP_INSTR, validF=0, PCF=faddr.
//  - validF is forced to 0 whenever PCSrcE=1; instrF is NOP_INSTR whenever validF=0.
//  Latency
//  - Request at cycle n gives validF=1 at n+1; steady-state throughput is 1 instr/cycle.
//  Stall (StallF=1, PCSrcE=0)
//  - If rsp_valid=1 and hold_valid=0: capture imem_rdata/rsp_pc into hold; hold_valid<=1; rsp_valid<=0.
//  - faddr and hold are unchanged; outputs stable, bit-identical, every stalled cycle.
//  - At most one entry ever needs holding, because no request is issued while stalled.
//  Stall release (first cycle with StallF=0)
//  - Held entry is presented and consumed that cycle; hold_valid<=0.
//  - A request for faddr is issued in the same cycle, so there is no bubble after release.
//  Redirect (PCSrcE=1)
//  - Highest priority; overrides StallF.
//  - faddr<={PCTargetE[WIDTH-1:2],2'b00}; rsp_valid<=0; hold_valid<=0; in-flight data discarded.
//  - The target request issues on the next cycle that has StallF=0.
//  - Penalty: validF=0 in the redirect cycle and the following cycle; target valid on the 3rd cycle.
//  Simultaneous events
//  - StallF and PCSrcE together: treat as redirect; no capture into hold.
//  - Reset asserted mid-operation: all state is discarded immediately.
//  - After reset release, the first request goes to RESET_PC.
// TESTING
//  1. RESET_PC=0, mem[a]=a^32'hA5A50000; release rst -> validF=1 next cycle with PCF=0; then PCF=4,8,C on consecutive cycles; PCPlus4F=PCF+4.
//  2. StallF=1 for 3 cycles while PCF=8 -> PCF=8, instrF=mem[8] stable and imem_req=0 for 3 cycles; release -> PCF=8 once, then PCF=C with no bubble.
//  3. PCSrcE=1, PCTargetE=0x103 while PCF=0x10 -> validF=0 for 2 cycles; next valid PCF=0x100, instrF=mem[0x100].
//  4. PCSrcE=1 (target 0x40) during an active stall with hold full -> hold discarded; once StallF=0, first valid PCF=0x40; stale instruction never seen.
//  5. RESET_PC=32'hFFFFFFFC -> PCF=FFFFFFFC, PCPlus4F=0, next PCF=0.
//  6. Assert rst asynchronously mid-stream -> validF=0 and imem_req=0 before the next clk edge; after release, the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// and feeds the FEC->DEC register with a one-entry hold buffer for stalls and EXE redirects.
module fetch_stage #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [WIDTH-1:0]  NOP_INSTR = 'h13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] instrF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic             validF
);

    logic [WIDTH-1:0] faddr;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_pc;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_pc;
    logic [WIDTH-1:0] hold_instr;

    logic             issue;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_pc;
    logic [WIDTH-1:0] sel_instr;

    // A redirect or a stall suppresses the request; reset silences it immediately.
    assign issue     = ~rst & ~StallF & ~PCSrcE;
    assign imem_req  = issue;
    assign imem_addr = faddr;

    // Request stage: fetch address, in-flight response tag and the hold buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            faddr      <= RESET_PC;
            rsp_valid  <= 1'b0;
            rsp_pc     <= '0;
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else if (PCSrcE) begin
            // Mask the low bits instead of slicing so every target bit is consumed.
            faddr      <= PCTargetE & ~WIDTH'(3);
            rsp_valid  <= 1'b0;
            hold_valid <= 1'b0;
        end else if (StallF) begin
            if (rsp_valid && !hold_valid) begin
                hold_instr <= imem_rdata;
                hold_pc    <= rsp_pc;
                hold_valid <= 1'b1;
                rsp_valid  <= 1'b0;
            end
        end else begin
            faddr      <= faddr + WIDTH'(4);
            rsp_valid  <= 1'b1;
            rsp_pc     <= faddr;
            hold_valid <= 1'b0;
        end
    end

    // Response stage: pick hold buffer, live memory data, or a bubble
    always_comb begin
        sel_valid = 1'b0;
        sel_pc    = faddr;
        sel_instr = NOP_INSTR;
        if (hold_valid) begin
            sel_valid = 1'b1;
            sel_pc    = hold_pc;
            sel_instr = hold_instr;
        end else if (rsp_valid) begin
            sel_valid = 1'b1;
            sel_pc    = rsp_pc;
            sel_instr = imem_rdata;
        end
        if (PCSrcE) begin
            sel_valid = 1'b0;
        end
        if (rst) begin
            sel_valid = 1'b0;
            sel_pc    = '0;
        end
    end

    assign validF   = sel_valid;
    assign instrF   = sel_valid ? sel_instr : NOP_INSTR;
    assign PCF      = sel_pc;
    assign PCPlus4F = sel_pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus randomized
// stall/redirect traffic checked every cycle against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PCF, instrF, PCPlus4F;
    logic        validF;

    logic        req5;
    logic [31:0] addr5, rdata5, pcf5, instr5, pcp5;
    logic        valid5;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h00000000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .PCF(PCF), .instrF(instrF), .PCPlus4F(PCPlus4F), .validF(validF)
    );

    fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFFFFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(rst), .StallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem_req(req5), .imem_addr(addr5), .imem_rdata(rdata5),
        .PCF(pcf5), .instrF(instr5), .PCPlus4F(pcp5), .validF(valid5)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A50000;
    endfunction

    // Synchronous-read memories; unrequested cycles return junk so stale data is exposed.
    always @(posedge clk) imem_rdata <= imem_req ? mem(imem_addr) : $urandom();
    always @(posedge clk) rdata5     <= req5     ? mem(addr5)     : $urandom();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Model: the stage owes at most one instruction (pend), whether in flight or held.
    initial begin
        logic [31:0] next_pc, pend_pc, tgt;
        logic        pend_v, s, r, exp_v, exp_req;
        next_pc = 32'h0;
        pend_pc = 32'h0;
        pend_v  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                next_pc = 32'h0;
                pend_v  = 1'b0;
                chk1("m_rst_validF", validF, 1'b0);
                chk1("m_rst_req", imem_req, 1'b0);
                chk("m_rst_PCF", PCF, 32'h0);
                chk("m_rst_PCPlus4F", PCPlus4F, 32'h4);
                chk("m_rst_instrF", instrF, NOP);
            end else begin
                exp_v   = pend_v && !PCSrcE;
                exp_req = !StallF && !PCSrcE;
                chk1("m_validF", validF, exp_v);
                chk("m_instrF", instrF, exp_v ? mem(pend_pc) : NOP);
                if (exp_v) begin
                    chk("m_PCF", PCF, pend_pc);
                    chk("m_PCPlus4F", PCPlus4F, pend_pc + 32'd4);
                end else if (!PCSrcE) begin
                    chk("m_PCF_idle", PCF, next_pc);
                end
                chk1("m_req", imem_req, exp_req);
                if (exp_req) chk("m_addr", imem_addr, next_pc);
            end
            s   = StallF;
            r   = PCSrcE;
            tgt = PCTargetE;
            @(posedge clk);
            if (rst) begin
                next_pc = 32'h0;
                pend_v  = 1'b0;
            end else if (r) begin
                next_pc = tgt & ~32'd3;
                pend_v  = 1'b0;
            end else if (!s) begin
                pend_v  = 1'b1;
                pend_pc = next_pc;
                next_pc = next_pc + 32'd4;
            end
        end
    end

    task automatic cyc(input logic s, input logic r, input logic [31:0] t);
        @(negedge clk);
        StallF    = s;
        PCSrcE    = r;
        PCTargetE = t;
        #2;
    endtask

    initial begin
        @(negedge clk);
        #2;
        chk1("reset_validF", validF, 1'b0);
        chk("reset_instrF", instrF, NOP);
        chk("reset_PCF", PCF, 32'h0);
        chk("reset_PCPlus4F", PCPlus4F, 32'h4);
        chk1("reset_req", imem_req, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        #2;
        chk1("rel_req", imem_req, 1'b1);
        chk("rel_addr", imem_addr, 32'h0);
        chk1("rel_validF", validF, 1'b0);

        cyc(0, 0, 0);
        chk1("seq0_valid", validF, 1'b1);
        chk("seq0_PCF", PCF, 32'h0);
        chk("seq0_instr", instrF, 32'hA5A50000);
        chk("seq0_PCPlus4F", PCPlus4F, 32'h4);
        chk1("wrap_valid", valid5, 1'b1);
        chk("wrap_PCF", pcf5, 32'hFFFFFFFC);
        chk("wrap_PCPlus4F", pcp5, 32'h0);
        cyc(0, 0, 0);
        chk("seq1_PCF", PCF, 32'h4);
        chk("wrap_next_PCF", pcf5, 32'h0);

        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            chk("stall_PCF", PCF, 32'h8);
            chk("stall_instr", instrF, 32'hA5A50008);
            chk1("stall_req", imem_req, 1'b0);
        end
        cyc(0, 0, 0);
        chk("release_PCF", PCF, 32'h8);
        chk1("release_req", imem_req, 1'b1);
        chk("release_addr", imem_addr, 32'hC);
        cyc(0, 0, 0);
        chk("after_release_PCF", PCF, 32'hC);
        chk1("after_release_valid", validF, 1'b1);

        cyc(0, 1, 32'h103);
        chk1("redir_valid0", validF, 1'b0);
        cyc(0, 0, 0);
        chk1("redir_valid1", validF, 1'b0);
        chk("redir_addr", imem_addr, 32'h100);
        cyc(0, 0, 0);
        chk("redir_PCF", PCF, 32'h100);
        chk("redir_instr", instrF, 32'hA5A50100);

        cyc(1, 0, 0);
        chk("hold_PCF", PCF, 32'h104);
        cyc(1, 1, 32'h40);
        chk1("stall_redir_valid", validF, 1'b0);
        cyc(1, 0, 0);
        chk1("stall_after_redir_valid", validF, 1'b0);
        chk1("stall_after_redir_req", imem_req, 1'b0);
        cyc(0, 0, 0);
        chk1("target_issue_valid", validF, 1'b0);
        chk("target_issue_addr", imem_addr, 32'h40);
        cyc(0, 0, 0);
        chk("target_PCF", PCF, 32'h40);
        chk("target_instr", instrF, 32'hA5A50040);

        for (int i = 0; i < 500; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1023));
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, t);
        end

        cyc(0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_valid", validF, 1'b0);
        chk1("async_rst_req", imem_req, 1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk1("rerel_req", imem_req, 1'b1);
        chk("rerel_addr", imem_addr, 32'h0);
        cyc(0, 0, 0);
        chk("rerel_PCF", PCF, 32'h0);
        chk1("rerel_valid", validF, 1'b1);
        cyc(0, 0, 0);
        chk("rerel_PCF2", PCF, 32'h4);

        for (int i = 0; i < 100; i++) begin
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 32'($urandom_range(0, 255)));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
